// File: rtl/ldpc_axis_pkg.sv
// ldpc_axis_pkg: stat_err bit positions, receiver FSM states and a popcount helper
// shared by the LDPC decoder ingress/egress AXI-Stream blocks.
package ldpc_axis_pkg;
   localparam int ERR_KEEP_GAP  = 0;
   localparam int ERR_KEEP_ZERO = 1;
   localparam int ERR_OVERLEN   = 2;
   typedef enum logic [1:0] {S_IDLE, S_IN_FRAME, S_STAT} rx_state_e;
   function automatic logic [15:0] popcount(input logic [127:0] v);
      popcount = '0;
      for (int i = 0; i < 128; i++) popcount = popcount + 16'(v[i]);
   endfunction
endpackage

// File: rtl/axis_skid_buffer.sv
// axis_skid_buffer: 2-entry AXI-Stream register slice with registered s_ready,
// 1-cycle latency and full throughput.
module axis_skid_buffer #(
   parameter int DATA_WIDTH = 64
) (
   input  logic                    aclk,
   input  logic                    aresetn,
   input  logic                    s_valid,
   output logic                    s_ready,
   input  logic [DATA_WIDTH-1:0]   s_data,
   input  logic [DATA_WIDTH/8-1:0] s_keep,
   input  logic                    s_last,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic [DATA_WIDTH-1:0]   m_data,
   output logic [DATA_WIDTH/8-1:0] m_keep,
   output logic                    m_last
);
   logic                    sk_valid;
   logic [DATA_WIDTH-1:0]   sk_data;
   logic [DATA_WIDTH/8-1:0] sk_keep;
   logic                    sk_last;
   logic                    in_fire, out_en;
   assign in_fire = s_valid && s_ready;
   assign out_en  = !m_valid || m_ready;
   // s_ready is only low while the skid entry is occupied, so in_fire never
   // coincides with a skid drain
   always_ff @(posedge aclk or negedge aresetn)
      if (!aresetn) begin
         s_ready  <= 1'b0;
         m_valid  <= 1'b0;
         m_data   <= '0;
         m_keep   <= '0;
         m_last   <= 1'b0;
         sk_valid <= 1'b0;
         sk_data  <= '0;
         sk_keep  <= '0;
         sk_last  <= 1'b0;
      end else if (out_en) begin
         m_valid  <= sk_valid || in_fire;
         if (sk_valid) {m_data, m_keep, m_last} <= {sk_data, sk_keep, sk_last};
         else if (in_fire) {m_data, m_keep, m_last} <= {s_data, s_keep, s_last};
         sk_valid <= 1'b0;
         s_ready  <= 1'b1;
      end else if (in_fire) begin
         {sk_data, sk_keep, sk_last} <= {s_data, s_keep, s_last};
         sk_valid <= 1'b1;
         s_ready  <= 1'b0;
      end
endmodule

// File: rtl/axis_frame_receiver.sv
// axis_frame_receiver: AXIS ingress endpoint that forwards frames through a skid
// buffer, measures byte length, checks tkeep framing and emits one descriptor per frame.
module axis_frame_receiver
   import ldpc_axis_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int MAX_BYTES  = 1056,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                    aclk,
   input  logic                    aresetn,
   input  logic                    s_axis_tvalid,
   output logic                    s_axis_tready,
   input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
   input  logic                    s_axis_tlast,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic [DATA_WIDTH-1:0]   m_axis_tdata,
   output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
   output logic                    m_axis_tlast,
   output logic                    stat_valid,
   input  logic                    stat_ready,
   output logic [LEN_WIDTH-1:0]    stat_len,
   output logic [2:0]              stat_err
);
   localparam int KW = DATA_WIDTH / 8;
   localparam logic [LEN_WIDTH:0] MAX_L = (LEN_WIDTH + 1)'(MAX_BYTES);
   rx_state_e            state, state_n;
   logic [LEN_WIDTH-1:0] cnt;
   logic [LEN_WIDTH:0]   sum;
   logic [2:0]           err, beat_err;
   logic                 skid_ready, in_stat, accept;
   assign in_stat       = state == S_STAT;
   assign s_axis_tready = skid_ready && !in_stat;
   assign accept        = s_axis_tvalid && s_axis_tready;
   assign sum           = {1'b0, cnt} + (LEN_WIDTH + 1)'(popcount(128'(s_axis_tkeep)));
   // contiguous LSB-aligned masks have no carry gap: k & (k+1) == 0
   assign beat_err[ERR_KEEP_GAP]  = |(s_axis_tkeep & (s_axis_tkeep + KW'(1)));
   assign beat_err[ERR_KEEP_ZERO] = s_axis_tkeep == '0;
   assign beat_err[ERR_OVERLEN]   = sum > MAX_L;
   axis_skid_buffer #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
      .aclk    (aclk),
      .aresetn (aresetn),
      .s_valid (s_axis_tvalid && !in_stat),
      .s_ready (skid_ready),
      .s_data  (s_axis_tdata),
      .s_keep  (s_axis_tkeep),
      .s_last  (s_axis_tlast),
      .m_valid (m_axis_tvalid),
      .m_ready (m_axis_tready),
      .m_data  (m_axis_tdata),
      .m_keep  (m_axis_tkeep),
      .m_last  (m_axis_tlast)
   );
   always_comb begin
      state_n    = state;
      stat_valid = in_stat;
      stat_len   = in_stat ? cnt : '0;
      stat_err   = in_stat ? err : '0;
      case (state)
         S_IDLE:     if (accept) state_n = s_axis_tlast ? S_STAT : S_IN_FRAME;
         S_IN_FRAME: if (accept && s_axis_tlast) state_n = S_STAT;
         S_STAT:     if (stat_ready) state_n = S_IDLE;
         default:    state_n = S_IDLE;
      endcase
   end
   always_ff @(posedge aclk or negedge aresetn)
      if (!aresetn) begin
         state <= S_IDLE;
         cnt   <= '0;
         err   <= '0;
      end else begin
         state <= state_n;
         if (in_stat && stat_ready) begin
            cnt <= '0;
            err <= '0;
         end else if (accept) begin
            cnt <= sum[LEN_WIDTH] ? '1 : sum[LEN_WIDTH-1:0];
            err <= err | beat_err;
         end
      end
endmodule

// File: tb/tb_axis_frame_receiver.sv
// tb_axis_frame_receiver: directed frame table plus hand-written stall, hold-off,
// reset-abort and random-backpressure sequences with a beat/descriptor scoreboard.
module tb_axis_frame_receiver;
   logic        aclk = 0, aresetn = 0;
   logic        s_valid = 0, s_ready, s_last = 0;
   logic [63:0] s_data = '0;
   logic [7:0]  s_keep = '0;
   logic        m_valid, m_ready = 1, m_last;
   logic [63:0] m_data;
   logic [7:0]  m_keep;
   logic        stat_valid, stat_ready = 1;
   logic [15:0] stat_len;
   logic [2:0]  stat_err;

   always #5 aclk = ~aclk;

   axis_frame_receiver #(.DATA_WIDTH(64), .MAX_BYTES(1056), .LEN_WIDTH(16)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_axis_tvalid(s_valid), .s_axis_tready(s_ready), .s_axis_tdata(s_data),
      .s_axis_tkeep(s_keep), .s_axis_tlast(s_last),
      .m_axis_tvalid(m_valid), .m_axis_tready(m_ready), .m_axis_tdata(m_data),
      .m_axis_tkeep(m_keep), .m_axis_tlast(m_last),
      .stat_valid(stat_valid), .stat_ready(stat_ready), .stat_len(stat_len), .stat_err(stat_err)
   );

   typedef struct {logic [63:0] d; logic [7:0] k; logic l; int c;} beat_t;
   typedef struct {logic [15:0] len; logic [2:0] err;} desc_t;
   typedef struct {int n; int mid; logic [7:0] mk; logic [7:0] lk; logic [15:0] len; logic [2:0] err;} vec_t;

   int    total = 0, bad = 0, cyc = 0;
   beat_t exp_q[$];
   desc_t stat_q[$];
   bit    lat_en = 0, rand_en = 0, rdy_seen = 0, stall = 0, sstall = 0;
   beat_t held;
   desc_t sheld;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   always @(posedge aclk) cyc++;

   always @(posedge aclk) if (rand_en) begin
      #1;
      m_ready = 1'($urandom_range(0, 1));
   end

   always @(negedge aclk) begin
      if (!aresetn) begin
         stall = 0;
         sstall = 0;
         rdy_seen = 0;
      end else begin
         if (stall) begin
            chk("m_hold_valid", m_valid, 1);
            chk("m_hold_data", m_data, held.d);
            chk("m_hold_keep", m_keep, held.k);
            chk("m_hold_last", m_last, held.l);
         end
         if (sstall) begin
            chk("stat_hold_valid", stat_valid, 1);
            chk("stat_hold_len", stat_len, sheld.len);
            chk("stat_hold_err", stat_err, sheld.err);
         end
         if (s_ready) rdy_seen = 1;
         else if (rdy_seen && !stat_valid) chk("s_ready_low_needs_full", m_valid, 1);
         if (s_valid && s_ready) exp_q.push_back('{s_data, s_keep, s_last, cyc});
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL extra_beat: got %0h want none", m_data);
            end else begin
               beat_t e;
               e = exp_q.pop_front();
               chk("beat_data", m_data, e.d);
               chk("beat_keep", m_keep, e.k);
               chk("beat_last", m_last, e.l);
               if (lat_en) chk("latency", cyc - e.c, 1);
            end
         end
         if (stat_valid && stat_ready) begin
            if (stat_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL extra_desc: got len %0d want none", stat_len);
            end else begin
               desc_t e;
               e = stat_q.pop_front();
               chk("stat_len", stat_len, e.len);
               chk("stat_err", stat_err, e.err);
            end
         end
         stall = m_valid && !m_ready;
         held = '{m_data, m_keep, m_last, 0};
         sstall = stat_valid && !stat_ready;
         sheld = '{stat_len, stat_err};
      end
   end

   task automatic wait_ready();
      int w = 0;
      @(negedge aclk);
      while (!s_ready && w < 1000) begin
         @(negedge aclk);
         w++;
      end
      if (!s_ready) begin
         total++;
         bad++;
         $display("FAIL ready_timeout: got 0 want 1");
      end
      @(posedge aclk);
      #1;
   endtask

   task automatic send_frame(input int n, input int mid, input logic [7:0] mk, input logic [7:0] lk,
                             input logic [15:0] len, input logic [2:0] err);
      stat_q.push_back('{len, err});
      for (int i = 0; i < n; i++) begin
         s_valid = 1;
         s_data = {$urandom(), $urandom()};
         s_keep = (i == n - 1) ? lk : (i == mid) ? mk : 8'hFF;
         s_last = (i == n - 1);
         wait_ready();
      end
      s_valid = 0;
      s_last = 0;
      chk("stat_valid_after_last", stat_valid, 1);
   endtask

   task automatic drain();
      int w = 0;
      while ((exp_q.size() != 0 || stat_q.size() != 0) && w < 5000) begin
         @(posedge aclk);
         w++;
      end
      chk("drain_beats", exp_q.size(), 0);
      chk("drain_desc", stat_q.size(), 0);
      @(posedge aclk);
      #1;
   endtask

   task automatic chk_zero();
      chk("rst_s_ready", s_ready, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_m_keep", m_keep, 0);
      chk("rst_m_last", m_last, 0);
      chk("rst_stat_valid", stat_valid, 0);
      chk("rst_stat_len", stat_len, 0);
      chk("rst_stat_err", stat_err, 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[10];
      int   n, k;
      tbl[0] = '{8,   -1, 8'hFF, 8'hFF, 16'd64,   3'b000};
      tbl[1] = '{8,   -1, 8'hFF, 8'h0F, 16'd60,   3'b000};
      tbl[2] = '{4,    1, 8'h0B, 8'hFF, 16'd27,   3'b001};
      tbl[3] = '{4,    2, 8'h00, 8'hFF, 16'd24,   3'b010};
      tbl[4] = '{133, -1, 8'hFF, 8'hFF, 16'd1064, 3'b100};
      tbl[5] = '{132, -1, 8'hFF, 8'hFF, 16'd1056, 3'b000};
      tbl[6] = '{1,   -1, 8'hFF, 8'h01, 16'd1,    3'b000};
      tbl[7] = '{1,   -1, 8'hFF, 8'h00, 16'd0,    3'b010};
      tbl[8] = '{1,   -1, 8'hFF, 8'h80, 16'd1,    3'b001};
      tbl[9] = '{133,  5, 8'h0B, 8'hFF, 16'd1059, 3'b101};
      repeat (2) @(negedge aclk);
      chk_zero();
      @(posedge aclk);
      #1 aresetn = 1;
      @(negedge aclk);
      chk("ready_before_first_edge", s_ready, 0);
      @(posedge aclk);
      #1;
      chk("ready_after_first_edge", s_ready, 1);
      lat_en = 1;
      for (int i = 0; i < 10; i++) begin
         send_frame(tbl[i].n, tbl[i].mid, tbl[i].mk, tbl[i].lk, tbl[i].len, tbl[i].err);
         drain();
      end
      // descriptor held off: input must stay blocked until the stat handshake
      stat_ready = 0;
      send_frame(2, -1, 8'hFF, 8'h03, 16'd10, 3'b000);
      s_valid = 1;
      s_data = 64'h1111;
      s_keep = 8'hFF;
      for (int i = 0; i < 10; i++) begin
         @(negedge aclk);
         chk("hold_s_ready", s_ready, 0);
         chk("hold_stat_valid", stat_valid, 1);
      end
      @(posedge aclk);
      #1 stat_ready = 1;
      @(negedge aclk);
      chk("s_ready_in_stat_handshake", s_ready, 0);
      @(posedge aclk);
      #1;
      send_frame(3, -1, 8'hFF, 8'hFF, 16'd24, 3'b000);
      drain();
      // reset in the middle of a 6-beat frame
      for (int i = 0; i < 2; i++) begin
         s_valid = 1;
         s_data = {$urandom(), $urandom()};
         s_keep = 8'hFF;
         wait_ready();
      end
      s_data = 64'h3333;
      aresetn = 0;
      exp_q.delete();
      for (int i = 0; i < 3; i++) begin
         @(negedge aclk);
         chk_zero();
      end
      @(posedge aclk);
      #1 aresetn = 1;
      @(negedge aclk);
      chk("ready_low_after_release", s_ready, 0);
      @(posedge aclk);
      #1 s_valid = 0;
      send_frame(6, -1, 8'hFF, 8'hFF, 16'd48, 3'b000);
      drain();
      lat_en = 0;
      rand_en = 1;
      for (int f = 0; f < 20; f++) begin
         n = $urandom_range(1, 40);
         k = $urandom_range(1, 8);
         send_frame(n, -1, 8'hFF, 8'((1 << k) - 1), 16'((n - 1) * 8 + k), 3'b000);
      end
      drain();
      rand_en = 0;
      @(posedge aclk);
      #2 m_ready = 1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
